// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states, error
// codes, frame layout and the length-legality helper.
package program_loader_pkg;

  // Default build parameters
  localparam int unsigned MAX_LEN_DEF = 31;
  localparam int unsigned TIMEOUT_DEF = 1000;
  localparam int unsigned TMO_W_DEF   = 10;

  // Frame layout: one length byte, L program bytes, one XOR checksum byte
  localparam int unsigned HDR_BYTES  = 1;
  localparam int unsigned CSUM_BYTES = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_LEN  = 3'd1,
    ERR_OVF  = 3'd2,
    ERR_CSUM = 3'd3,
    ERR_TMO  = 3'd4
  } err_e;

  // A length byte is usable when it is non-zero and fits the buffer
  function automatic logic len_legal(input logic [7:0] len, input int unsigned max_len);
    return (len != 8'd0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream, program-buffer and status signals of the program loader.
// slave = the loader itself; master = the surrounding system (RX source,
// program buffer and CPU-side observers).
interface program_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       reload;
  logic       buf_full;
  logic       buf_wr;
  logic [7:0] buf_data;
  logic       buf_clear;
  logic       cpu_run;
  logic       load_busy;
  logic       load_err;
  logic [2:0] err_code;
  logic [5:0] byte_count;

  modport slave (
    input  rx_data, rx_valid, reload, buf_full,
    output rx_ready, buf_wr, buf_data, buf_clear, cpu_run,
           load_busy, load_err, err_code, byte_count
  );

  modport master (
    output rx_data, rx_valid, reload, buf_full,
    input  rx_ready, buf_wr, buf_data, buf_clear, cpu_run,
           load_busy, load_err, err_code, byte_count
  );
endinterface

// File: rtl/program_loader_gap_timer.sv
// Inter-byte gap counter. Counts enabled cycles since the last clear and
// flags the cycle on which the gap reaches TIMEOUT cycles.
module loader_gap_timer #(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TMO_W   = 10
) (
  input  logic CPU_Clk,
  input  logic Reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] gap_q;
  logic [TMO_W-1:0] gap_d;

  // Next gap value: clear wins, then count up and hold at the last value
  always_comb begin
    // NOTE: default assignment first so every path drives gap_d and no latch is inferred.
    gap_d = gap_q;
    if (clr_i) begin
      gap_d = '0;
    end else if (en_i && (gap_q != LAST)) begin
      gap_d = gap_q + TMO_W'(1);
    end
  end

  // Gap register
  always_ff @(posedge CPU_Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (Reset) gap_q <= '0;
    else       gap_q <= gap_d;
  end

  // The TIMEOUT-th idle cycle; an accept in the same cycle clears instead
  assign expired_o = en_i && !clr_i && (gap_q == LAST);

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: receives a length byte, L program bytes and an
// XOR checksum, streams the program into the CPU buffer and releases the CPU.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TMO_W   = TMO_W_DEF
) (
  input  logic             CPU_Clk,
  input  logic             Reset,
  program_loader_if.slave  bus
);

  localparam logic [5:0] MAX_CNT = 6'(MAX_LEN);

  state_e     state_q;
  err_e       err_q;
  logic [7:0] len_q;
  logic [7:0] xor_q;
  logic [5:0] cnt_q;
  logic       armed_q;   // low during Reset and until the first edge after it

  logic       rx_ready;
  logic       accept;
  logic       expired;
  logic       gap_clr;
  logic       gap_en;
  logic [5:0] cnt_inc;
  logic       last_byte;
  logic       full_early;

  // Handshake readiness decoded from the registered state
  always_comb begin
    rx_ready = 1'b0;
    unique case (state_q)
      ST_IDLE:  rx_ready = armed_q;
      ST_LOAD:  rx_ready = !bus.buf_full;
      ST_CHECK: rx_ready = 1'b1;
      default:  rx_ready = 1'b0;
    endcase
  end

  assign accept     = bus.rx_valid && rx_ready;
  assign cnt_inc    = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 6'd1;
  assign last_byte  = ({2'b00, cnt_inc} == len_q);
  assign full_early = bus.buf_full && ({2'b00, cnt_q} < len_q);

  assign gap_en  = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign gap_clr = bus.reload || accept || (state_q == ST_CLEAR);

  loader_gap_timer #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_gap_timer (
    .CPU_Clk   (CPU_Clk),
    .Reset     (Reset),
    .clr_i     (gap_clr),
    .en_i      (gap_en),
    .expired_o (expired)
  );

  // Loader FSM with length, checksum, byte count and error registers
  always_ff @(posedge CPU_Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      len_q   <= 8'd0;
      xor_q   <= 8'd0;
      cnt_q   <= 6'd0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (bus.reload) begin
        state_q <= ST_IDLE;
        err_q   <= ERR_NONE;
        xor_q   <= 8'd0;
        cnt_q   <= 6'd0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (accept) begin
              len_q <= bus.rx_data;
              if (len_legal(bus.rx_data, MAX_LEN)) begin
                state_q <= ST_CLEAR;
                cnt_q   <= 6'd0;
                xor_q   <= 8'd0;
              end else begin
                state_q <= ST_ERROR;
                err_q   <= ERR_LEN;
              end
            end
          end
          ST_CLEAR: state_q <= ST_LOAD;
          ST_LOAD: begin
            if (full_early) begin
              state_q <= ST_ERROR;
              err_q   <= ERR_OVF;
            end else if (accept) begin
              xor_q <= xor_q ^ bus.rx_data;
              cnt_q <= cnt_inc;
              if (last_byte) state_q <= ST_CHECK;
            end else if (expired) begin
              state_q <= ST_ERROR;
              err_q   <= ERR_TMO;
            end
          end
          ST_CHECK: begin
            if (accept) begin
              if (bus.rx_data == xor_q) begin
                state_q <= ST_RUN;
              end else begin
                state_q <= ST_ERROR;
                err_q   <= ERR_CSUM;
              end
            end else if (expired) begin
              state_q <= ST_ERROR;
              err_q   <= ERR_TMO;
            end
          end
          default: state_q <= state_q;   // RUN and ERROR wait for reload
        endcase
      end
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.buf_wr     = accept && (state_q == ST_LOAD);
  assign bus.buf_data   = bus.rx_data;
  assign bus.buf_clear  = (state_q == ST_CLEAR);
  assign bus.cpu_run    = (state_q == ST_RUN);
  assign bus.load_busy  = (state_q == ST_CLEAR) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign bus.load_err   = (state_q == ST_ERROR);
  assign bus.err_code   = err_q;
  assign bus.byte_count = cnt_q;

endmodule
